// File: rtl/control_unit.sv
// Two-state fetch/execute controller: latches an instruction word, decodes it for one cycle, advances PC.
// Optional jump/beq support is compiled in with the BRANCH_EN macro; without it opcodes 0x06/0x07 are illegal NOPs.
module control_unit #(
  parameter int unsigned PC_STEP = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        INSTR_BUSYWAIT,
  input  logic        ALU_ZERO,
  output logic [31:0] PC,
  output logic        INSTR_READ,
  output logic        WRITE,
  output logic [2:0]  INADDRESS,
  output logic [2:0]  OUT1ADDRESS,
  output logic [2:0]  OUT2ADDRESS,
  output logic [7:0]  IMMEDIATE,
  output logic [2:0]  ALUOP,
  output logic        IMM_SEL,
  output logic        NEG_SEL,
  output logic        ILLEGAL
);

`ifdef BRANCH_EN
  localparam bit BranchEn = 1'b1;
`else
  localparam bit BranchEn = 1'b0;
`endif

  typedef enum logic {FETCH, EXECUTE} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        taken;
  logic [31:0] br_off;
  logic        unused_ir;

  // Branch offset is a signed word count relative to the sequential successor.
  assign br_off      = {{22{ir_q[23]}}, ir_q[23:16], 2'b00};
  assign unused_ir   = ^ir_q[15:11];

  assign PC          = pc_q;
  assign INADDRESS   = ir_q[18:16];
  assign OUT1ADDRESS = ir_q[10:8];
  assign OUT2ADDRESS = ir_q[2:0];
  assign IMMEDIATE   = ir_q[7:0];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= FETCH;
      pc_q    <= 32'd0;
      ir_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    taken      = 1'b0;
    INSTR_READ = 1'b0;
    WRITE      = 1'b0;
    ALUOP      = 3'b000;
    IMM_SEL    = 1'b0;
    NEG_SEL    = 1'b0;
    ILLEGAL    = 1'b0;
    case (state_q)
      FETCH: begin
        INSTR_READ = 1'b1;
        if (!INSTR_BUSYWAIT) begin
          ir_d    = INSTRUCTION;
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        state_d = FETCH;
        case (ir_q[31:24])
          8'h00: begin WRITE = 1'b1; IMM_SEL = 1'b1; end
          8'h01: WRITE = 1'b1;
          8'h02: begin WRITE = 1'b1; ALUOP = 3'b001; end
          8'h03: begin WRITE = 1'b1; ALUOP = 3'b001; NEG_SEL = 1'b1; end
          8'h04: begin WRITE = 1'b1; ALUOP = 3'b010; end
          8'h05: begin WRITE = 1'b1; ALUOP = 3'b011; end
          8'h06: begin
            if (BranchEn) taken = 1'b1;
            else          ILLEGAL = 1'b1;
          end
          8'h07: begin
            if (BranchEn) begin
              ALUOP   = 3'b001;
              NEG_SEL = 1'b1;
              taken   = ALU_ZERO;
            end else begin
              ILLEGAL = 1'b1;
            end
          end
          default: ILLEGAL = 1'b1;
        endcase
        pc_d = pc_q + 32'(PC_STEP) + (taken ? br_off : 32'd0);
      end
      default: state_d = FETCH;
    endcase
    // Reset must silence the memory/register-file strobes before any edge arrives.
    if (RESET) begin
      INSTR_READ = 1'b0;
      WRITE      = 1'b0;
      IMM_SEL    = 1'b0;
      NEG_SEL    = 1'b0;
      ILLEGAL    = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed literal checks followed by randomized instructions against a behavioural model.
module tb_control_unit;

`ifdef BRANCH_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic        INSTR_BUSYWAIT;
  logic        ALU_ZERO;
  logic [31:0] PC;
  logic        INSTR_READ, WRITE, IMM_SEL, NEG_SEL, ILLEGAL;
  logic [2:0]  INADDRESS, OUT1ADDRESS, OUT2ADDRESS, ALUOP;
  logic [7:0]  IMMEDIATE;

  int checks   = 0;
  int failures = 0;
  bit run      = 1'b0;

  control_unit #(.PC_STEP(4)) dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION),
    .INSTR_BUSYWAIT(INSTR_BUSYWAIT), .ALU_ZERO(ALU_ZERO),
    .PC(PC), .INSTR_READ(INSTR_READ), .WRITE(WRITE),
    .INADDRESS(INADDRESS), .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .IMMEDIATE(IMMEDIATE), .ALUOP(ALUOP), .IMM_SEL(IMM_SEL),
    .NEG_SEL(NEG_SEL), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
    end
  endtask

  // Expected decode: {write, imm_sel, neg_sel, illegal, aluop[2:0]}
  function automatic logic [6:0] dec(input logic [7:0] op);
    case (op)
      8'h00: return 7'b1100_000;
      8'h01: return 7'b1000_000;
      8'h02: return 7'b1000_001;
      8'h03: return 7'b1010_001;
      8'h04: return 7'b1000_010;
      8'h05: return 7'b1000_011;
      8'h06: return BR ? 7'b0000_000 : 7'b0001_000;
      8'h07: return BR ? 7'b0010_001 : 7'b0001_000;
      default: return 7'b0001_000;
    endcase
  endfunction

  // Behavioural model: phase (fetching or executing), PC and latched instruction.
  bit          m_exec = 1'b0;
  logic [31:0] m_pc   = 32'd0;
  logic [31:0] m_ir   = 32'd0;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_exec = 1'b0;
      m_pc   = 32'd0;
      m_ir   = 32'd0;
    end else if (!m_exec) begin
      if (!INSTR_BUSYWAIT) begin
        m_ir   = INSTRUCTION;
        m_exec = 1'b1;
      end
    end else begin
      int off;
      off = $signed(m_ir[23:16]) * 4;
      m_exec = 1'b0;
      if (BR && (m_ir[31:24] == 8'h06 || (m_ir[31:24] == 8'h07 && ALU_ZERO)))
        m_pc = m_pc + 32'd4 + 32'(off);
      else
        m_pc = m_pc + 32'd4;
    end
  end

  always @(negedge CLK) begin
    if (run) begin
      if (RESET) begin
        chk("rst_pc", PC, 32'd0);
        chk("rst_instr_read", 32'(INSTR_READ), 32'd0);
        chk("rst_write", 32'(WRITE), 32'd0);
        chk("rst_illegal", 32'(ILLEGAL), 32'd0);
      end else begin
        logic [6:0] e;
        e = m_exec ? dec(m_ir[31:24]) : 7'd0;
        chk("pc", PC, m_pc);
        chk("instr_read", 32'(INSTR_READ), 32'(!m_exec));
        chk("inaddr", 32'(INADDRESS), 32'(m_ir[18:16]));
        chk("out1addr", 32'(OUT1ADDRESS), 32'(m_ir[10:8]));
        chk("out2addr", 32'(OUT2ADDRESS), 32'(m_ir[2:0]));
        chk("immediate", 32'(IMMEDIATE), 32'(m_ir[7:0]));
        chk("write", 32'(WRITE), 32'(e[6]));
        chk("imm_sel", 32'(IMM_SEL), 32'(e[5]));
        chk("neg_sel", 32'(NEG_SEL), 32'(e[4]));
        chk("illegal", 32'(ILLEGAL), 32'(e[3]));
        if (m_exec && !e[3]) chk("aluop", 32'(ALUOP), 32'(e[2:0]));
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic instr(input logic [31:0] w);
    INSTRUCTION    = w;
    INSTR_BUSYWAIT = 1'b0;
    cyc();
  endtask

  task automatic run_instr(input logic [31:0] w);
    instr(w);
    cyc();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    cyc();
    cyc();
    RESET = 1'b0;
    #1;
  endtask

  initial begin
    logic [7:0] op;
    RESET = 1'b1; INSTRUCTION = 32'd0; INSTR_BUSYWAIT = 1'b0; ALU_ZERO = 1'b0;
    run = 1'b1;
    cyc(); cyc();
    chk("lit_rst_pc", PC, 32'd0);
    chk("lit_rst_read", 32'(INSTR_READ), 32'd0);
    RESET = 1'b0;
    #1;
    chk("lit_read_after_rst", 32'(INSTR_READ), 32'd1);

    instr(32'h0002005F);
    chk("lit_loadi_write", 32'(WRITE), 32'd1);
    chk("lit_loadi_inaddr", 32'(INADDRESS), 32'd2);
    chk("lit_loadi_imm", 32'(IMMEDIATE), 32'd95);
    chk("lit_loadi_immsel", 32'(IMM_SEL), 32'd1);
    cyc();
    chk("lit_loadi_pc", PC, 32'd4);

    INSTRUCTION = 32'h03010203; INSTR_BUSYWAIT = 1'b1;
    repeat (3) begin
      cyc();
      chk("lit_stall_pc", PC, 32'd4);
      chk("lit_stall_ir", 32'(OUT1ADDRESS), 32'd0);
    end
    instr(32'h03010203);
    chk("lit_sub_write", 32'(WRITE), 32'd1);
    chk("lit_sub_neg", 32'(NEG_SEL), 32'd1);
    chk("lit_sub_aluop", 32'(ALUOP), 32'd1);
    chk("lit_sub_out1", 32'(OUT1ADDRESS), 32'd2);
    chk("lit_sub_out2", 32'(OUT2ADDRESS), 32'd3);
    cyc();
    chk("lit_sub_pc", PC, 32'd8);

`ifdef BRANCH_EN
    ALU_ZERO = 1'b1;
    instr(32'h07FE0000);
    chk("lit_beq_write", 32'(WRITE), 32'd0);
    cyc();
    chk("lit_beq_taken_pc", PC, 32'd4);
    run_instr(32'h01000000);
    ALU_ZERO = 1'b0;
    run_instr(32'h07FE0000);
    chk("lit_beq_not_taken_pc", PC, 32'd12);
    run_instr(32'h06020000);
    chk("lit_j_pc", PC, 32'd24);
    do_reset();
    run_instr(32'h06FE0000);
    chk("lit_j_back_pc", PC, 32'hFFFFFFFC);
    run_instr(32'h01000000);
    chk("lit_pc_wrap", PC, 32'd0);
`else
    do_reset();
    instr(32'h06000000);
    chk("lit_op06_illegal", 32'(ILLEGAL), 32'd1);
    chk("lit_op06_write", 32'(WRITE), 32'd0);
    cyc();
    chk("lit_op06_pc", PC, 32'd4);
    instr(32'hFF000000);
    chk("lit_opff_illegal", 32'(ILLEGAL), 32'd1);
    chk("lit_opff_write", 32'(WRITE), 32'd0);
    cyc();
    chk("lit_opff_pc", PC, 32'd8);
`endif

    do_reset();
    repeat (4) run_instr(32'h01000000);
    chk("lit_pc16", PC, 32'd16);
    instr(32'h02010101);
    chk("lit_add_write", 32'(WRITE), 32'd1);
    #1 RESET = 1'b1;
    #1;
    chk("lit_abort_write", 32'(WRITE), 32'd0);
    chk("lit_abort_pc", PC, 32'd0);
    chk("lit_abort_read", 32'(INSTR_READ), 32'd0);
    cyc();
    RESET = 1'b0;
    #1;
    chk("lit_abort_pc_after", PC, 32'd0);
    chk("lit_abort_read_after", 32'(INSTR_READ), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(9))
        8: op = 8'hFF;
        9: op = 8'($urandom);
        default: op = 8'($urandom_range(7));
      endcase
      RESET          = ($urandom_range(99) == 0);
      INSTR_BUSYWAIT = ($urandom_range(9) < 3);
      ALU_ZERO       = 1'($urandom_range(1));
      INSTRUCTION    = {op, 24'($urandom)};
      cyc();
    end
    RESET = 1'b0;
    repeat (4) cyc();
    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter PC_STEP, default 4: byte increment applied to PC per sequential instruction.
REQ-002 CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 INSTRUCTION  input  32  instruction word from instruction memory: [31:24] opcode, [18:16] rd, [10:8] rt, [7:0] rs/imm.
REQ-005 INSTR_BUSYWAIT  input  1  instruction memory stall; data on INSTRUCTION is valid when low while INSTR_READ is high.
REQ-006 ALU_ZERO  input  1  ALU result-is-zero flag, sampled for beq.
REQ-007 PC  output  32  current instruction address.
REQ-008 INSTR_READ  output  1  fetch request to instruction memory.
REQ-009 WRITE, INADDRESS[2:0], OUT1ADDRESS[2:0], OUT2ADDRESS[2:0]  output  register-file write enable and addresses.
REQ-010 IMMEDIATE  output  8  immediate operand (IR[7:0]).
REQ-011 ALUOP  output  3  000 forward, 001 add, 010 and, 011 or.
REQ-012 IMM_SEL, NEG_SEL  output  1 each  select immediate as operand 2; select two's-complement of operand 2.
REQ-013 ILLEGAL  output  1  current instruction opcode is not supported.

Function
REQ-014 FSM states SHALL be FETCH and EXECUTE; no other reachable state.
REQ-015 FETCH: INSTR_READ=1; on a rising edge with INSTR_BUSYWAIT=0, IR<=INSTRUCTION and state->EXECUTE; otherwise stay in FETCH with IR unchanged.
REQ-016 EXECUTE SHALL last exactly one cycle, then state->FETCH; minimum 2 cycles per instruction.
REQ-017 In FETCH, WRITE, IMM_SEL, NEG_SEL and ILLEGAL SHALL be 0; decode outputs are combinational from IR and valid only in EXECUTE.
REQ-018 OUT1ADDRESS=IR[10:8], OUT2ADDRESS=IR[2:0], INADDRESS=IR[18:16] in all states.
REQ-019 Decode in EXECUTE: 0x00 loadi (WRITE=1, IMM_SEL=1, ALUOP=000); 0x01 mov (WRITE=1, ALUOP=000); 0x02 add (WRITE=1, ALUOP=001); 0x03 sub (WRITE=1, ALUOP=001, NEG_SEL=1); 0x04 and (WRITE=1, ALUOP=010); 0x05 or (WRITE=1, ALUOP=011).
REQ-020 Any opcode not decoded SHALL give WRITE=0, ILLEGAL=1 in EXECUTE, and PC advances by PC_STEP (treated as NOP).
REQ-021 PC update at the rising edge ending EXECUTE: PC<=PC+PC_STEP unless a taken branch (REQ-027); PC arithmetic is 32-bit modulo, wrapping 0xFFFFFFFC->0x00000000.
REQ-022 PC SHALL not change in FETCH, including across any number of INSTR_BUSYWAIT cycles.
REQ-023 WRITE SHALL be high for exactly one rising edge per writing instruction.

Reset
REQ-024 RESET high SHALL immediately force state=FETCH, PC=0, IR=0, and hold INSTR_READ=0, WRITE=0, ILLEGAL=0 without waiting for a clock edge.
REQ-025 RESET asserted mid-EXECUTE SHALL abort the instruction: no write, no PC update.
REQ-026 After RESET falls, INSTR_READ=1 and the first fetch is from address 0.

Configuration
REQ-027 Macro BRANCH_EN defined: 0x06 j (WRITE=0, PC<=PC+PC_STEP+sext(IR[23:16])*4); 0x07 beq (WRITE=0, ALUOP=001, NEG_SEL=1, branch taken iff ALU_ZERO=1, same target; else PC+PC_STEP).
REQ-028 BRANCH_EN undefined: 0x06 and 0x07 SHALL be handled as illegal per REQ-020.

Verification
REQ-029 RESET high 2 cycles, INSTR_BUSYWAIT=0 -> PC=0, INSTR_READ=0 during reset, INSTR_READ=1 first cycle after.
REQ-030 loadi r2,95 (0x0002005F) -> in EXECUTE WRITE=1, INADDRESS=2, IMMEDIATE=95, IMM_SEL=1; PC 0->4.
REQ-031 sub r1,r2,r3 with INSTR_BUSYWAIT high 3 cycles -> PC held at 4, IR unchanged, then WRITE=1, NEG_SEL=1, ALUOP=001, OUT1ADDRESS=2, OUT2ADDRESS=3; PC->8.
REQ-032 BRANCH_EN: beq offset 0xFE at PC=8, ALU_ZERO=1 -> PC=4; same with ALU_ZERO=0 -> PC=12; j offset 0x02 at PC=12 -> PC=24.
REQ-033 Without BRANCH_EN: opcode 0x06 at PC=0 -> ILLEGAL=1, WRITE=0, PC=4; opcode 0xFF -> same.
REQ-034 RESET pulse during EXECUTE of add at PC=16 -> WRITE drops immediately, no register write, PC=0, state FETCH.
